// File: rtl/recip_div_pkg.sv
// ============================================================================
// Module      : recip_div_pkg
// Description : Shared types and constants for the reciprocal-ROM divider.
//               The state enum, the product width for the default
//               16x16 multiply, the divide-by-zero quotient and the value
//               the div1024 ROM holds at entry 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package recip_div_pkg;

  // Divider sequencer states. CORR1/CORR2 only occur in the
  // RECIP_DIV_CORRECT_EN build.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAIT  = 3'd2,
    S_MUL   = 3'd3,
    S_CORR1 = 3'd4,
    S_CORR2 = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int DEF_NUM_WIDTH  = 16;
  localparam int DEF_DATA_WIDTH = 16;

  // Full-precision num*recip width for the default configuration.
  localparam int PROD_WIDTH = DEF_NUM_WIDTH + DEF_DATA_WIDTH;

  // Quotient reported for a zero denominator (all ones).
  localparam logic [DEF_NUM_WIDTH-1:0] c_DZ_QUOT = '1;

  // The ROM stores 0xFFFF at address 0; its data is ignored for den==0.
  localparam logic [DEF_DATA_WIDTH-1:0] c_ROM_ZERO_ENTRY = 16'hFFFF;

endpackage : recip_div_pkg

`default_nettype wire

// File: rtl/recip_div_corr.sv
// ============================================================================
// Module      : recip_div_corr
// Description : One combinational quotient-correction step.
//               r  = num - q*den
//               if (r >= den) { q' = q+1; r' = r-den } else { q' = q; r' = r }
//               The step is suppressed for den==0 so q never wraps.
// Ports       : i_num  numerator
//               i_den  denominator
//               i_q    current quotient estimate (never above floor(num/den))
//               o_q    corrected quotient
//               o_r    remainder belonging to o_q
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module recip_div_corr #(
  parameter int NUM_WIDTH  = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic [NUM_WIDTH-1:0]  i_num,
  input  logic [ADDR_WIDTH-1:0] i_den,
  input  logic [NUM_WIDTH-1:0]  i_q,
  output logic [NUM_WIDTH-1:0]  o_q,
  output logic [NUM_WIDTH-1:0]  o_r
);

  // Wide enough for q*den; since q <= floor(num/den) the subtraction
  // below cannot go negative.
  localparam int c_MW = NUM_WIDTH + ADDR_WIDTH;

  logic [c_MW-1:0] w_qd;
  logic [c_MW-1:0] w_den_ext;
  logic [c_MW-1:0] w_r_full;
  logic            w_step;

  assign w_qd      = c_MW'(i_q) * c_MW'(i_den);
  assign w_den_ext = c_MW'(i_den);
  assign w_r_full  = c_MW'(i_num) - w_qd;
  assign w_step    = (i_den != '0) && (w_r_full >= w_den_ext);

  assign o_q = w_step ? (i_q + 1'b1) : i_q;
  assign o_r = NUM_WIDTH'(w_step ? (w_r_full - w_den_ext) : w_r_full);

endmodule : recip_div_corr

`default_nettype wire

// File: rtl/recip_div_reader.sv
// ============================================================================
// Module      : recip_div_reader
// Description : Unsigned divider built around the div1024 reciprocal ROM.
//               A request (num, den) is accepted on a valid/ready handshake.
//               den addresses the ROM, and the returned reciprocal
//               floor(65535/den) is multiplied by num. The upper NUM_WIDTH
//               bits of the product are the quotient estimate. This estimate
//               may be up to 2 below the true floor quotient.
//               Optional macro RECIP_DIV_CORRECT_EN adds two fixed correction
//               cycles. These make the quotient exact and produce the
//               remainder. Without the macro, o_out_rem is tied to 0.
// Ports       : clk            system clock
//               rst_n          asynchronous active-low reset
//               i_in_valid     request valid
//               o_in_ready     request ready (high only when idle)
//               i_in_num       numerator
//               i_in_den       denominator (also the ROM address)
//               o_rom_addr     to div1024 addr (holds between requests)
//               i_rom_rd_data  from div1024 rd_data
//               o_out_valid    result valid
//               i_out_ready    result consumer ready
//               o_out_quot     quotient (all ones on divide by zero)
//               o_out_rem      remainder (0 without RECIP_DIV_CORRECT_EN)
//               o_out_dz       divide-by-zero flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module recip_div_reader
  import recip_div_pkg::*;
#(
  parameter int NUM_WIDTH   = 16,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [NUM_WIDTH-1:0]  i_in_num,
  input  logic [ADDR_WIDTH-1:0] i_in_den,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_rd_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [NUM_WIDTH-1:0]  o_out_quot,
  output logic [ADDR_WIDTH-1:0] o_out_rem,
  output logic                  o_out_dz
);

  localparam int c_PROD_W = NUM_WIDTH + DATA_WIDTH;

  state_t                r_state;
  logic [NUM_WIDTH-1:0]  r_num;
  logic [ADDR_WIDTH-1:0] r_den;
  logic [NUM_WIDTH-1:0]  r_q;
  logic [3:0]            r_wait_cnt;

  logic [c_PROD_W-1:0]   w_prod;
  logic [NUM_WIDTH-1:0]  w_q_est;
  logic                  w_dz;

  // Full-precision product. The quotient estimate is prod >> DATA_WIDTH.
  assign w_prod  = c_PROD_W'(r_num) * c_PROD_W'(i_rom_rd_data);
  assign w_q_est = NUM_WIDTH'(w_prod >> DATA_WIDTH);
  assign w_dz    = (r_den == '0);

`ifdef RECIP_DIV_CORRECT_EN
  logic [NUM_WIDTH-1:0]  w_corr_q;
  logic [NUM_WIDTH-1:0]  w_corr_r;
  logic [ADDR_WIDTH-1:0] r_rem;

  // A single correction step is shared by CORR1 and CORR2. In each state
  // it operates on the registered q from the state before.
  recip_div_corr #(
    .NUM_WIDTH  (NUM_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_corr (
    .i_num (r_num),
    .i_den (r_den),
    .i_q   (r_q),
    .o_q   (w_corr_q),
    .o_r   (w_corr_r)
  );
`else
  assign o_out_rem = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_den       <= '0;
      r_q         <= '0;
      r_wait_cnt  <= '0;
      o_in_ready  <= 1'b0;
      o_rom_addr  <= '0;
      o_out_valid <= 1'b0;
      o_out_quot  <= '0;
      o_out_dz    <= 1'b0;
`ifdef RECIP_DIV_CORRECT_EN
      r_rem       <= '0;
      o_out_rem   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // o_in_ready comes up one cycle after reset release.
          if (o_in_ready && i_in_valid) begin
            r_num      <= i_in_num;
            r_den      <= i_in_den;
            o_rom_addr <= i_in_den;
            o_in_ready <= 1'b0;
            r_state    <= S_ADDR;
          end else begin
            o_in_ready <= 1'b1;
          end
        end

        S_ADDR: begin
          // The ROM samples o_rom_addr on the edge that leaves this state.
          r_wait_cnt <= '0;
          r_state    <= (ROM_LATENCY > 1) ? S_WAIT : S_MUL;
        end

        S_WAIT: begin
          if (r_wait_cnt == 4'(ROM_LATENCY - 2)) begin
            r_state <= S_MUL;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end

        S_MUL: begin
          r_q <= w_q_est;
`ifdef RECIP_DIV_CORRECT_EN
          r_state <= S_CORR1;
`else
          r_state <= S_DONE;
`endif
        end

`ifdef RECIP_DIV_CORRECT_EN
        S_CORR1: begin
          r_q     <= w_corr_q;
          r_rem   <= ADDR_WIDTH'(w_corr_r);
          r_state <= S_CORR2;
        end

        S_CORR2: begin
          r_q     <= w_corr_q;
          r_rem   <= ADDR_WIDTH'(w_corr_r);
          r_state <= S_DONE;
        end
`endif

        S_DONE: begin
          // The first DONE cycle loads the output registers. After that,
          // the outputs stay frozen until the consumer takes them.
          if (!o_out_valid) begin
            o_out_valid <= 1'b1;
            o_out_quot  <= w_dz ? '1 : r_q;
            o_out_dz    <= w_dz;
`ifdef RECIP_DIV_CORRECT_EN
            o_out_rem   <= w_dz ? '0 : r_rem;
`endif
          end else if (i_out_ready) begin
            o_out_valid <= 1'b0;
            o_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule : recip_div_reader

`default_nettype wire

// File: tb/tb_recip_div_reader.sv
// ============================================================================
// Module      : tb_recip_div_reader
// Description : Directed testbench for recip_div_reader. Two instances share
//               the same stimulus. dut1 uses ROM_LATENCY=1 and a plain ROM
//               model. dut2 uses ROM_LATENCY=2 and a ROM model with an output
//               register. Expected results are hand-computed for both builds
//               (RECIP_DIV_CORRECT_EN defined or not).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_recip_div_reader;

  localparam int NW = 16;
  localparam int AW = 10;
  localparam int DW = 16;

`ifdef RECIP_DIV_CORRECT_EN
  localparam int c_LAT  = 5;
  localparam bit c_CORR = 1'b1;
`else
  localparam int c_LAT  = 3;
  localparam bit c_CORR = 1'b0;
`endif

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [NW-1:0] in_num    = '0;
  logic [AW-1:0] in_den    = '0;

  logic          rdy1, rdy2, ov1, ov2, dz1, dz2;
  logic [NW-1:0] quot1, quot2;
  logic [AW-1:0] rem1, rem2, addr1, addr2;
  logic [DW-1:0] rd1, rd2, rd2_stage;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // div1024 contents: floor(65535/k), entry 0 = 0xFFFF.
  function automatic logic [DW-1:0] recip(input logic [AW-1:0] k);
    if (k == '0) return 16'hFFFF;
    return DW'(32'd65535 / 32'(k));
  endfunction

  // ROM with OUTPUT_REG=0: data valid in the cycle after the address edge.
  always @(posedge clk) rd1 <= recip(addr1);
  // ROM with OUTPUT_REG=1: one additional output register stage.
  always @(posedge clk) begin
    rd2_stage <= recip(addr2);
    rd2       <= rd2_stage;
  end

  recip_div_reader #(.NUM_WIDTH(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy1),
    .i_in_num(in_num), .i_in_den(in_den), .o_rom_addr(addr1), .i_rom_rd_data(rd1),
    .o_out_valid(ov1), .i_out_ready(out_ready), .o_out_quot(quot1),
    .o_out_rem(rem1), .o_out_dz(dz1)
  );

  recip_div_reader #(.NUM_WIDTH(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(rdy2),
    .i_in_num(in_num), .i_in_den(in_den), .o_rom_addr(addr2), .i_rom_rd_data(rd2),
    .o_out_valid(ov2), .i_out_ready(out_ready), .o_out_quot(quot2),
    .o_out_rem(rem2), .o_out_dz(dz2)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One request through both DUTs. eq_nc/eq_c are the expected quotients
  // without/with correction; er_c is the exact remainder. hold = number of
  // backpressure cycles applied after out_valid.
  task automatic xfer(input string name, input logic [NW-1:0] num, input logic [AW-1:0] den,
                      input logic [NW-1:0] eq_nc, input logic [NW-1:0] eq_c,
                      input logic [AW-1:0] er_c, input logic edz, input int hold);
    int            n;
    int            lat1;
    int            lat2;
    bit            stable;
    logic [NW-1:0] eq;
    logic [AW-1:0] er;
    eq = c_CORR ? eq_c : eq_nc;
    er = c_CORR ? er_c : '0;

    n = 0;
    while (!(rdy1 && rdy2) && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk_eq({name, "_idle_rdy"}, 32'(rdy1 & rdy2), 32'd1);

    in_valid = 1'b1; in_num = num; in_den = den; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk_eq({name, "_busy_rdy"}, 32'(rdy1 | rdy2), 32'd0);
    chk_eq({name, "_rom_addr"}, 32'(addr1), 32'(den));

    lat1 = 0; lat2 = 0; n = 0;
    while ((lat1 == 0 || lat2 == 0) && n < 30) begin
      @(posedge clk); n++; @(negedge clk);
      if (lat1 == 0 && ov1) lat1 = n;
      if (lat2 == 0 && ov2) lat2 = n;
    end
    chk_eq({name, "_lat1"}, 32'(lat1), 32'(c_LAT));
    chk_eq({name, "_lat2"}, 32'(lat2), 32'(c_LAT + 1));
    chk_eq({name, "_quot1"}, 32'(quot1), 32'(eq));
    chk_eq({name, "_rem1"},  32'(rem1),  32'(er));
    chk_eq({name, "_dz1"},   32'(dz1),   32'(edz));
    chk_eq({name, "_quot2"}, 32'(quot2), 32'(eq));
    chk_eq({name, "_rem2"},  32'(rem2),  32'(er));
    chk_eq({name, "_dz2"},   32'(dz2),   32'(edz));

    if (hold > 0) begin
      // A competing request sits on the input during backpressure.
      stable = 1'b1;
      in_valid = 1'b1; in_num = 16'd1; in_den = 10'd1;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); @(negedge clk);
        if (!ov1 || !ov2 || rdy1 || rdy2 || quot1 !== eq || quot2 !== eq ||
            rem1 !== er || rem2 !== er || dz1 !== edz || dz2 !== edz)
          stable = 1'b0;
      end
      chk_eq({name, "_bp_stable"}, 32'(stable), 32'd1);
    end

    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk_eq({name, "_post_valid"}, 32'(ov1 | ov2), 32'd0);
    // Still ready means the held request was not taken at the handshake edge.
    chk_eq({name, "_post_rdy"}, 32'(rdy1 & rdy2), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  quiet;

    repeat (2) @(negedge clk);
    chk_eq("rst_in_ready", 32'(rdy1 | rdy2), 32'd0);
    chk_eq("rst_out_valid", 32'(ov1 | ov2), 32'd0);
    chk_eq("rst_quot", 32'(quot1), 32'd0);
    chk_eq("rst_rem", 32'(rem1), 32'd0);
    chk_eq("rst_dz", 32'(dz1), 32'd0);
    chk_eq("rst_rom_addr", 32'(addr1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_eq("rel_in_ready", 32'(rdy1 & rdy2), 32'd1);

    //        name          num     den    q(no corr) q(corr) rem  dz hold
    xfer("v1000_10",   16'd1000,  10'd10,   16'd99,  16'd100,  10'd0, 1'b0, 0);
    xfer("v65535_1",   16'd65535, 10'd1,    16'd65534, 16'd65535, 10'd0, 1'b0, 0);
    xfer("v1234_0",    16'd1234,  10'd0,    16'hFFFF, 16'hFFFF, 10'd0, 1'b1, 0);
    xfer("v700_7",     16'd700,   10'd7,    16'd99,  16'd100,  10'd0, 1'b0, 0);
    xfer("v1000_7_bp", 16'd1000,  10'd7,    16'd142, 16'd142,  10'd6, 1'b0, 5);
    xfer("v65535_1023",16'd65535, 10'd1023, 16'd63,  16'd64,   10'd63, 1'b0, 0);
    xfer("v5_1000",    16'd5,     10'd1000, 16'd0,   16'd0,    10'd5, 1'b0, 0);

    // Reset pulse while dut1 is in MUL (one edge after ADDR).
    n = 0;
    while (!(rdy1 && rdy2) && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
    end
    in_valid = 1'b1; in_num = 16'd1000; in_den = 10'd10;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_eq("mrst_out_valid", 32'(ov1 | ov2), 32'd0);
    chk_eq("mrst_rom_addr", 32'(addr1 | addr2), 32'd0);
    chk_eq("mrst_in_ready", 32'(rdy1 | rdy2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk_eq("mrst_rel_rdy", 32'(rdy1 & rdy2), 32'd1);
    quiet = 1'b1;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (ov1 || ov2) quiet = 1'b0;
    end
    chk_eq("mrst_no_result", 32'(quiet), 32'd1);

    xfer("v500_5", 16'd500, 10'd5, 16'd99, 16'd100, 10'd0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_recip_div_reader

`default_nettype wire
